// File: rtl/cart_load_ctrl.sv
// Cartridge download controller: streams host download bytes into cart RAM and latches detector results.
// Optional feature: define CART_CHECKSUM_EN to add an 8-bit running checksum output.
module cart_load_ctrl #(
  parameter logic [7:0] ROM_INDEX     = 8'h00,
  parameter int         MAX_SIZE      = 65536,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [3:0]  det_force_bs,
  input  logic        det_sc,
  output logic [31:0] cart_size,
  output logic [3:0]  bs,
  output logic        sc,
  output logic        cpu_reset,
`ifdef CART_CHECKSUM_EN
  output logic [7:0]  checksum,
`endif
  output logic        done
);

  // Memory handshake: mem_we holds mem_addr/mem_din stable until the cycle mem_ack=1;
  // ioctl_wait mirrors mem_we so the host never issues a byte while one is pending.
  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, SETTLE, LATCH, READY
  } state_t;

  localparam logic [31:0] MAX_SIZE_W  = 32'(MAX_SIZE);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       dl_match;
  logic       in_range;
  logic       accept;
  logic       load_entry;

  assign dl_match   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign in_range   = ({7'd0, ioctl_addr} < MAX_SIZE_W);
  assign accept     = (state == LOAD) && dl_match && ioctl_wr && in_range;
  assign load_entry = (state_next == LOAD) && ((state == IDLE) || (state == READY));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, READY: begin
        if (dl_match) state_next = LOAD;
      end
      LOAD: begin
        if (!ioctl_download) state_next = SETTLE;
        else if (accept)     state_next = WRITE;
      end
      WRITE: begin
        // A falling download only takes effect once the pending byte is acknowledged.
        if (mem_ack) state_next = ioctl_download ? LOAD : SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = LATCH;
      end
      LATCH: begin
        state_next = READY;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_wait <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'd0;
      mem_din    <= 8'd0;
      cart_size  <= 32'd0;
      bs         <= 4'd0;
      sc         <= 1'b0;
      done       <= 1'b0;
      cpu_reset  <= 1'b1;
      settle_cnt <= 4'd0;
    end else begin
      mem_we     <= (state_next == WRITE);
      ioctl_wait <= (state_next == WRITE);
      done       <= (state_next == READY);
      cpu_reset  <= (state_next != READY);

      if (state == SETTLE) settle_cnt <= settle_cnt + 4'd1;
      else                 settle_cnt <= 4'd0;

      if (load_entry) begin
        cart_size <= 32'd0;
      end else if (accept) begin
        mem_addr  <= ioctl_addr[15:0];
        mem_din   <= ioctl_dout;
        cart_size <= {7'd0, ioctl_addr} + 32'd1;
      end

      if (state == LATCH) begin
        bs <= det_force_bs;
        sc <= det_sc;
      end
    end
  end

`ifdef CART_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 8'd0;
    end else if (load_entry) begin
      checksum <= 8'd0;
    end else if (accept) begin
      checksum <= checksum + ioctl_dout;
    end
  end
`endif

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed bench for cart_load_ctrl: table of download scenarios plus reset/hold corner sequences.
module tb_cart_load_ctrl;

  localparam int SETTLE = 2;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_ack;
  logic [3:0]  det_force_bs;
  logic        det_sc;
  logic [31:0] cart_size;
  logic [3:0]  bs;
  logic        sc;
  logic        cpu_reset;
  logic        done;

  cart_load_ctrl dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_ack        (mem_ack),
    .det_force_bs   (det_force_bs),
    .det_sc         (det_sc),
    .cart_size      (cart_size),
    .bs             (bs),
    .sc             (sc),
    .cpu_reset      (cpu_reset),
    .done           (done)
  );

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // memory responder + scoreboard
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_delay = 1;
  int          ack_cnt = 0;
  int          we_pulses = 0;
  int          wait_cycles = 0;
  int          stable_err = 0;
  logic [15:0] hold_addr;
  logic [7:0]  hold_din;
  logic [23:0] exp_w;

  assign mem_ack = resp_ack | stray_ack;

  always @(negedge clk_sys) begin
    if (ioctl_wait) wait_cycles++;
    if (!reset_n) begin
      resp_ack = 1'b0;
      ack_cnt  = 0;
    end else if (resp_ack) begin
      resp_ack = 1'b0;
      ack_cnt  = 0;
    end else if (mem_we) begin
      if (ack_cnt == 0) begin
        we_pulses++;
        hold_addr = mem_addr;
        hold_din  = mem_din;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: write %h=%h, required no write", mem_addr, mem_din);
        end else begin
          exp_w = exp_q.pop_front();
          check("sb_write", {8'd0, mem_addr, mem_din}, {8'd0, exp_w});
        end
      end else if (mem_addr !== hold_addr || mem_din !== hold_din) begin
        stable_err++;
      end
      ack_cnt++;
      if (ack_cnt >= ack_delay) resp_ack = 1'b1;
    end
  end

  // driver tasks
  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input bit acc);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (acc) exp_q.push_back({a[15:0], d});
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    for (int i = 0; i < 100 && ioctl_wait; i++) @(negedge clk_sys);
    check("wait_release", {31'd0, ioctl_wait}, 32'd0);
  endtask

  task automatic end_download(output int lat);
    ioctl_download = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      lat++;
      if (done) break;
    end
  endtask

  typedef struct {
    logic [7:0]  idx;
    int          n;
    logic [24:0] base;
    int          delay;
    logic [3:0]  det_bs;
    logic        det_sc;
    logic [31:0] exp_size;
    int          exp_writes;
    logic [3:0]  exp_bs;
    logic        exp_sc;
    logic        exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic run_download(input vec_t r);
    int we0, w0, s0, lat;
    logic [24:0] a;
    ioctl_index  = r.idx;
    det_force_bs = r.det_bs;
    det_sc       = r.det_sc;
    ack_delay    = r.delay;
    we0 = we_pulses;
    w0  = wait_cycles;
    s0  = stable_err;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    if (r.idx == 8'h00) begin
      check("load_done_low", {31'd0, done}, 32'd0);
      check("load_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    end
    for (int i = 0; i < r.n; i++) begin
      a = r.base + 25'(i);
      write_byte(a, 8'($urandom_range(0, 255)), (r.idx == 8'h00) && (a < 25'h10000));
    end
    end_download(lat);
    if (r.idx == 8'h00) check("done_latency", 32'(lat), 32'(SETTLE + 2));
    check("cart_size", cart_size, r.exp_size);
    check("bs", {28'd0, bs}, {28'd0, r.exp_bs});
    check("sc", {31'd0, sc}, {31'd0, r.exp_sc});
    check("done", {31'd0, done}, {31'd0, r.exp_done});
    check("cpu_reset", {31'd0, cpu_reset}, {31'd0, !r.exp_done});
    check("we_pulses", 32'(we_pulses - we0), 32'(r.exp_writes));
    check("wait_cycles", 32'(wait_cycles - w0), 32'(r.exp_writes * r.delay));
    check("stable", 32'(stable_err - s0), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'h01, 4,    25'h0,     1, 4'h9, 1'b1, 32'h0,     0,    4'h0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 4096, 25'h0,     1, 4'h6, 1'b1, 32'h1000,  4096, 4'h6, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 8,    25'h100,   5, 4'h3, 1'b0, 32'h108,   8,    4'h3, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 4,    25'h40,    1, 4'h9, 1'b1, 32'h108,   0,    4'h3, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 0,    25'h0,     1, 4'h2, 1'b0, 32'h0,     0,    4'h2, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 3,    25'hFFFE,  2, 4'hF, 1'b1, 32'h10000, 2,    4'hF, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 5,    25'h1FFF0, 1, 4'h5, 1'b0, 32'h0,     0,    4'h5, 1'b0, 1'b1};

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    det_force_bs   = '0;
    det_sc         = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_din", {24'd0, mem_din}, 32'd0);
    check("rst_size", cart_size, 32'd0);
    check("rst_bs_sc", {27'd0, bs, sc}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk_sys);

    for (int v = 0; v < 7; v++) run_download(vecs[v]);

    // detector changes and a stray ack in READY must not disturb latched results
    det_force_bs = 4'hA;
    det_sc       = 1'b1;
    stray_ack    = 1'b1;
    @(negedge clk_sys);
    stray_ack = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("hold_bs", {28'd0, bs}, 32'h5);
    check("hold_sc", {31'd0, sc}, 32'd0);
    check("hold_we", {31'd0, mem_we}, 32'd0);
    check("hold_done", {31'd0, done}, 32'd1);

    // reset asserted while a write is outstanding
    ioctl_index    = 8'h00;
    ack_delay      = 8;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 25'h20;
    ioctl_dout = 8'h5A;
    exp_q.push_back({16'h0020, 8'h5A});
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check("mid_we_high", {31'd0, mem_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("mid_rst_size", cart_size, 32'd0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("reload_done_low", {31'd0, done}, 32'd0);
    ack_delay = 2;
    write_byte(25'h30, 8'hC3, 1'b1);
    write_byte(25'h31, 8'h3C, 1'b1);
    end_download(lat);
    check("reload_latency", 32'(lat), 32'(SETTLE + 2));
    check("reload_size", cart_size, 32'h32);
    check("reload_done", {31'd0, done}, 32'd1);
    check("reload_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cart_load_ctrl.md
CART_LOAD_CTRL -- requirements
Module: cart_load_ctrl

Interface
REQ-001 Parameter ROM_INDEX, default 8'h00, ioctl_index value accepted as a cartridge download.
REQ-002 Parameter MAX_SIZE, default 65536, byte limit; writes at or beyond it are discarded.
REQ-003 Parameter SETTLE_CYCLES, default 2, range 1..15, cycles waited after download end before latching detector outputs.
REQ-004 Ports (name direction width meaning), SHALL be exactly:
  clk_sys  in  1  sole clock, all logic on rising edge
  reset_n  in  1  reset, asynchronous, active-low
  ioctl_download  in  1  host download window
  ioctl_wr  in  1  host byte strobe, one cycle per byte
  ioctl_addr  in  25  byte address
  ioctl_dout  in  8  byte data
  ioctl_index  in  8  download type
  ioctl_wait  out  1  host stall
  mem_addr  out  16  cart RAM address
  mem_din  out  8  cart RAM data
  mem_we  out  1  write request, held until acknowledged
  mem_ack  in  1  one-cycle write completion
  det_force_bs  in  4  bank-switch scheme from detector
  det_sc  in  1  Superchip flag from detector
  cart_size  out  32  bytes loaded
  bs  out  4  latched bank-switch scheme
  sc  out  1  latched Superchip flag
  cpu_reset  out  1  holds console core in reset
  done  out  1  cartridge ready

Function
REQ-005 States SHALL be IDLE, LOAD, WRITE, SETTLE, LATCH, READY.
REQ-006 IDLE -> LOAD when ioctl_download=1 and ioctl_index=ROM_INDEX; other indices SHALL be ignored in every state.
REQ-007 On entering LOAD: cart_size<=0, done<=0, cpu_reset<=1, settle counter cleared.
REQ-008 In LOAD, ioctl_wr=1 with ioctl_addr<MAX_SIZE SHALL register mem_addr<=ioctl_addr[15:0], mem_din<=ioctl_dout, cart_size<=ioctl_addr+1 (32-bit zero-extended), and go to WRITE; mem_we and ioctl_wait go high the next cycle.
REQ-009 In LOAD, ioctl_wr=1 with ioctl_addr>=MAX_SIZE SHALL be dropped: no memory write, no stall, cart_size unchanged.
REQ-010 In WRITE, mem_we and ioctl_wait SHALL remain 1 until the cycle mem_ack=1; both SHALL be 0 the following cycle; the state returns to LOAD, or to SETTLE if ioctl_download is already 0.
REQ-011 ioctl_wr pulses arriving while ioctl_wait=1 are a host protocol violation and SHALL be ignored.
REQ-012 ioctl_download falling while in LOAD SHALL go to SETTLE; falling during WRITE SHALL complete the pending write first (REQ-010).
REQ-013 SETTLE SHALL count SETTLE_CYCLES clocks, then go to LATCH.
REQ-014 LATCH (one cycle) SHALL register bs<=det_force_bs, sc<=det_sc, and go to READY.
REQ-015 In READY: done=1, cpu_reset=0; bs, sc, cart_size held until the next matching download start, which re-enters LOAD per REQ-007.
REQ-016 A download ending with zero accepted bytes SHALL still reach READY with cart_size=0.
REQ-017 mem_ack outside WRITE SHALL be ignored.

Reset
REQ-018 reset_n=0 SHALL asynchronously force: state IDLE, ioctl_wait=0, mem_we=0, mem_addr=0, mem_din=0, cart_size=0, bs=0, sc=0, done=0, cpu_reset=1.
REQ-019 Reset asserted mid-write SHALL abandon the write; after release the block waits in IDLE for a fresh download rising edge (a download already high and matching re-enters LOAD).

Configuration
REQ-020 Macro CART_CHECKSUM_EN defined: extra output checksum (out, 8) = 8-bit modulo-256 sum of all bytes accepted per REQ-008, cleared on LOAD entry and on reset, stable in READY.
REQ-021 Macro CART_CHECKSUM_EN undefined: no checksum port or logic; all other behaviour identical.

Verification
REQ-022 Reset, download index 0 of 4096 bytes, mem_ack 1 cycle after mem_we -> cart_size=4096, 4096 mem_we pulses, done=1 after SETTLE_CYCLES+2 cycles from download fall.
REQ-023 mem_ack delayed 5 cycles -> ioctl_wait high exactly 5 cycles per byte, no byte lost, mem_addr/mem_din stable while mem_we=1.
REQ-024 Download index 8'h01 -> no mem_we, state stays IDLE, done stays 0.
REQ-025 det_force_bs=4'h6, det_sc=1 at LATCH -> bs=6, sc=1; change detector inputs in READY -> bs/sc unchanged.
REQ-026 Write at addr 65536 with MAX_SIZE=65536 -> no mem_we, no ioctl_wait, cart_size unchanged.
REQ-027 reset_n pulsed during WRITE -> mem_we=0, ioctl_wait=0, cpu_reset=1 immediately; second download completes normally.
